// File: rtl/sprite_row_renderer.sv
// Scanline sprite renderer: on every swap it advances one display row, walks
// the entity table in address order and copies the intersecting row of each
// entity's sprite from the sprite ROM into the line buffer. Pixels equal to the
// colour key and pixels past the right edge of the line are not written.
module sprite_row_renderer #(
  parameter int SPRITE_DIM = 48,
  parameter int LINE_W     = 640,
  parameter int FRAME_H    = 480,
  parameter int COORD_W    = 10,
  parameter int TYPE_W     = 3,
  parameter int ENT_ADDR_W = 8,
  parameter int PIX_W      = 24,
  parameter int ROM_ADDR_W = 17,
  parameter int ROM_LAT    = 1,
  parameter logic [PIX_W-1:0] TRANSPARENT = 24'hFF00FF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          swap,
  input  logic [ENT_ADDR_W-1:0]         entities_number,
  output logic [ENT_ADDR_W-1:0]         address_read_ent,
  input  logic [TYPE_W+2*COORD_W-1:0]   data_read_ent,
  output logic [ROM_ADDR_W-1:0]         address_read_rom,
  input  logic [PIX_W-1:0]              data_read_rom,
  output logic [COORD_W-1:0]            address_write_row,
  output logic [PIX_W-1:0]              data_write_row,
  output logic                          wren,
  output logic                          busy,
  output logic                          done,
  output logic                          overrun
);

  localparam int ENT_W    = TYPE_W + 2 * COORD_W;
  localparam int SPR_AREA = SPRITE_DIM * SPRITE_DIM;
  localparam int CNT_W    = $clog2(SPRITE_DIM + ROM_LAT + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_TEST, S_DRAW, S_DRAIN, S_FINISH
  } state_t;

  state_t                  state, state_nx;
  logic [COORD_W-1:0]      row;
  logic [ENT_ADDR_W-1:0]   ent_idx, ent_count, ent_idx_inc;
  logic [CNT_W-1:0]        cnt;
  logic [COORD_W:0]        draw_col;
  logic [ROM_ADDR_W-1:0]   rom_addr, base_addr;

  // Column/valid tags travelling alongside the ROM read, ROM_LAT deep.
  logic                    pipe_v   [ROM_LAT];
  logic [COORD_W:0]        pipe_col [ROM_LAT];

  // Entity word fields and hit test for the current row.
  logic [TYPE_W-1:0]       ent_type;
  logic [COORD_W-1:0]      ent_row, ent_col, row_off;
  logic [COORD_W:0]        row_end;
  logic                    hit, last_ent, pix_ok;

  assign ent_type    = data_read_ent[ENT_W-1 -: TYPE_W];
  assign ent_row     = data_read_ent[2*COORD_W-1 -: COORD_W];
  assign ent_col     = data_read_ent[COORD_W-1:0];
  // Bottom edge in one extra bit so sprites near the coordinate limit never wrap.
  assign row_end     = {1'b0, ent_row} + (COORD_W+1)'(SPRITE_DIM);
  assign hit         = (row >= ent_row) && ({1'b0, row} < row_end);
  assign row_off     = row - ent_row;
  assign base_addr   = ROM_ADDR_W'(ent_type) * ROM_ADDR_W'(SPR_AREA)
                     + ROM_ADDR_W'(row_off) * ROM_ADDR_W'(SPRITE_DIM);
  assign ent_idx_inc = ent_idx + 1'b1;
  assign last_ent    = (ent_idx_inc == ent_count);

  // Pixel leaving the ROM is written unless it is the colour key or off the line.
  assign pix_ok = pipe_v[ROM_LAT-1] && (data_read_rom != TRANSPARENT)
               && (pipe_col[ROM_LAT-1] < (COORD_W+1)'(LINE_W));

  assign address_read_ent = ent_idx;
  assign address_read_rom = rom_addr;
  assign busy = state inside {S_FETCH, S_TEST, S_DRAW, S_DRAIN};
  assign done = (state == S_FINISH);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block or statement order.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; a swap always restarts the walk, aborting if needed.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_nx
    // unassigned, which would otherwise infer a latch.
    state_nx = state;
    if (swap) begin
      state_nx = S_FETCH;
    end else begin
      case (state)
        S_FETCH:  state_nx = (ent_count == '0) ? S_FINISH : S_TEST;
        S_TEST:   state_nx = hit ? S_DRAW : (last_ent ? S_FINISH : S_FETCH);
        S_DRAW:   if (cnt == CNT_W'(SPRITE_DIM-1)) state_nx = S_DRAIN;
        S_DRAIN:  if (cnt == CNT_W'(ROM_LAT)) state_nx = last_ent ? S_FINISH : S_FETCH;
        S_FINISH: state_nx = S_IDLE;
        default:  state_nx = S_IDLE;
      endcase
    end
  end

  // Row counter, entity walk, ROM address generation and overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row       <= COORD_W'(FRAME_H-1);
      ent_idx   <= '0;
      ent_count <= '0;
      cnt       <= '0;
      draw_col  <= '0;
      rom_addr  <= '0;
      overrun   <= 1'b0;
    end else begin
      overrun <= swap && busy;
      if (swap) begin
        row       <= (row == COORD_W'(FRAME_H-1)) ? '0 : row + 1'b1;
        ent_idx   <= '0;
        ent_count <= entities_number;
        cnt       <= '0;
      end else begin
        case (state)
          S_TEST: begin
            if (hit) begin
              rom_addr <= base_addr;
              draw_col <= {1'b0, ent_col};
              cnt      <= '0;
            end else if (!last_ent) begin
              ent_idx  <= ent_idx_inc;
            end
          end
          S_DRAW: begin
            if (cnt == CNT_W'(SPRITE_DIM-1)) begin
              cnt      <= '0;
            end else begin
              cnt      <= cnt + 1'b1;
              rom_addr <= rom_addr + 1'b1;
              draw_col <= draw_col + 1'b1;
            end
          end
          S_DRAIN: begin
            if (cnt == CNT_W'(ROM_LAT)) begin
              cnt <= '0;
              if (!last_ent) ent_idx <= ent_idx_inc;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Tag pipeline aligned with ROM latency, then the registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the tag pipeline is a handful of flops, not a RAM, so it is
      // reset; a stale valid bit would otherwise fire a write after reset.
      for (int i = 0; i < ROM_LAT; i++) begin
        pipe_v[i]   <= 1'b0;
        pipe_col[i] <= '0;
      end
      wren              <= 1'b0;
      address_write_row <= '0;
      data_write_row    <= '0;
    end else if (swap) begin
      for (int i = 0; i < ROM_LAT; i++) pipe_v[i] <= 1'b0;
      wren              <= 1'b0;
      address_write_row <= '0;
      data_write_row    <= '0;
    end else begin
      pipe_v[0]   <= (state == S_DRAW);
      pipe_col[0] <= draw_col;
      for (int i = 1; i < ROM_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_col[i] <= pipe_col[i-1];
      end
      wren              <= pix_ok;
      address_write_row <= pix_ok ? pipe_col[ROM_LAT-1][COORD_W-1:0] : '0;
      data_write_row    <= pix_ok ? data_read_rom : '0;
    end
  end

endmodule

// File: tb/tb_sprite_row_renderer.sv
// Self-checking bench for sprite_row_renderer: entity RAM and sprite ROM models,
// a line-level reference model producing the expected write stream with cycle
// stamps, directed cases plus randomized entity tables.
module tb_sprite_row_renderer;

  localparam int SPRITE_DIM = 48;
  localparam int LINE_W     = 640;
  localparam int FRAME_H    = 480;
  localparam int COORD_W    = 10;
  localparam int TYPE_W     = 3;
  localparam int ENT_ADDR_W = 8;
  localparam int PIX_W      = 24;
  localparam int ROM_ADDR_W = 17;
  localparam int ROM_LAT    = 1;
  localparam logic [PIX_W-1:0] TRANSPARENT = 24'hFF00FF;
  localparam logic [PIX_W-1:0] RED  = 24'hFF0000;
  localparam logic [PIX_W-1:0] BLUE = 24'h0000FF;
  localparam int AREA = SPRITE_DIM * SPRITE_DIM;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic swap = 1'b0;
  logic [ENT_ADDR_W-1:0]       entities_number = '0;
  logic [ENT_ADDR_W-1:0]       address_read_ent;
  logic [TYPE_W+2*COORD_W-1:0] data_read_ent;
  logic [ROM_ADDR_W-1:0]       address_read_rom;
  logic [PIX_W-1:0]            data_read_rom;
  logic [COORD_W-1:0]          address_write_row;
  logic [PIX_W-1:0]            data_write_row;
  logic wren, busy, done, overrun;

  sprite_row_renderer #(
    .SPRITE_DIM(SPRITE_DIM), .LINE_W(LINE_W), .FRAME_H(FRAME_H), .COORD_W(COORD_W),
    .TYPE_W(TYPE_W), .ENT_ADDR_W(ENT_ADDR_W), .PIX_W(PIX_W), .ROM_ADDR_W(ROM_ADDR_W),
    .ROM_LAT(ROM_LAT), .TRANSPARENT(TRANSPARENT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .swap(swap), .entities_number(entities_number),
    .address_read_ent(address_read_ent), .data_read_ent(data_read_ent),
    .address_read_rom(address_read_rom), .data_read_rom(data_read_rom),
    .address_write_row(address_write_row), .data_write_row(data_write_row),
    .wren(wren), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Memory models: entity RAM with 1-cycle read, sprite ROM with 1-cycle read.
  logic [TYPE_W+2*COORD_W-1:0] ent_mem [0:255];
  logic [PIX_W-1:0]            rom_mem [0:(1<<ROM_ADDR_W)-1];
  always @(posedge clk) begin
    data_read_ent <= ent_mem[address_read_ent];
    data_read_rom <= rom_mem[address_read_rom];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: records {cycle, column, pixel}; flags stray write-port data.
  logic [63:0] writes [$];
  int idle_bad = 0;
  int ovr_cnt  = 0;
  always @(negedge clk) begin
    if (wren) writes.push_back({cyc[23:0], 16'(address_write_row), data_write_row});
    else if (address_write_row != '0 || data_write_row != '0) idle_bad++;
    if (overrun) ovr_cnt++;
  end

  int n_checks = 0;
  int n_errors = 0;
  int model_row;
  logic [PIX_W-1:0] lb_got [0:LINE_W-1];
  logic [PIX_W-1:0] lb_exp [0:LINE_W-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [TYPE_W+2*COORD_W-1:0] ent(input int ty, input int r, input int c);
    return {TYPE_W'(ty), COORD_W'(r), COORD_W'(c)};
  endfunction

  task automatic do_reset(input bit chk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    if (chk) begin
      check("rst_wren", wren, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_overrun", overrun, 0);
      check("rst_wr_addr", address_write_row, 0);
      check("rst_wr_data", data_write_row, 0);
      check("rst_ent_addr", address_read_ent, 0);
      check("rst_rom_addr", address_read_rom, 0);
    end
    repeat (2) @(negedge clk);
    writes.delete();
    model_row = FRAME_H - 1;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_swap(input int n, output int s);
    @(negedge clk);
    entities_number = ENT_ADDR_W'(n);
    swap = 1'b1;
    @(negedge clk);
    swap = 1'b0;
    s = cyc;
    model_row = (model_row == FRAME_H - 1) ? 0 : model_row + 1;
  endtask

  // Called at the negedge right after the swap edge (cycle s = first FETCH).
  task automatic expect_line(input string tag, input int s, input int n, output int n_got);
    logic [63:0] exp_q [$];
    logic [63:0] got_q [$];
    logic [PIX_W-1:0] pix;
    int t, ty, sr, sc, bc, done_c;
    t = s;
    for (int c = 0; c < LINE_W; c++) begin lb_got[c] = '0; lb_exp[c] = '0; end
    for (int i = 0; i < n; i++) begin
      ty = int'(ent_mem[i][TYPE_W+2*COORD_W-1 -: TYPE_W]);
      sr = int'(ent_mem[i][2*COORD_W-1 -: COORD_W]);
      sc = int'(ent_mem[i][COORD_W-1:0]);
      if (model_row >= sr && model_row < sr + SPRITE_DIM) begin
        for (int k = 0; k < SPRITE_DIM; k++) begin
          pix = rom_mem[(ty * AREA + (model_row - sr) * SPRITE_DIM + k) % (1 << ROM_ADDR_W)];
          if (pix != TRANSPARENT && sc + k < LINE_W) begin
            exp_q.push_back({24'(t + 2 + k + ROM_LAT + 1), 16'(sc + k), pix});
            lb_exp[sc + k] = pix;
          end
        end
        t += 2 + SPRITE_DIM + ROM_LAT + 1;
      end else begin
        t += 2;
      end
    end
    if (n == 0) t = s + 1;

    bc = int'(busy);
    done_c = -1;
    for (int w = 0; w < 4000; w++) begin
      @(negedge clk);
      if (done) begin done_c = cyc; break; end
      bc += int'(busy);
    end
    n_got = 0;
    if (done_c < 0) begin
      check({tag, "_timeout"}, 0, 1);
      return;
    end
    check({tag, "_done_cycle"}, done_c - s, t - s);
    check({tag, "_busy_cycles"}, bc, t - s);
    check({tag, "_busy_at_done"}, busy, 0);
    foreach (writes[i]) if (writes[i][63:40] >= 24'(s)) got_q.push_back(writes[i]);
    n_got = got_q.size();
    check({tag, "_n_writes"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({tag, "_write"}, got_q[i], exp_q[i]);
    foreach (got_q[i]) lb_got[int'(got_q[i][39:24]) % LINE_W] = got_q[i][23:0];
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int s, s2, ng, nw, n, d, nxt, sr;
    foreach (rom_mem[a]) rom_mem[a] = PIX_W'($urandom);
    foreach (ent_mem[a]) ent_mem[a] = '0;
    for (int k = 0; k < SPRITE_DIM; k++) begin
      rom_mem[1 * AREA + k] = 24'h100000 + PIX_W'(k);
      rom_mem[2 * AREA + k] = 24'h200000 + PIX_W'(k);
      rom_mem[3 * AREA + k] = RED;
      rom_mem[4 * AREA + k] = BLUE;
    end
    for (int k = 5; k <= 9; k++) rom_mem[2 * AREA + k] = TRANSPARENT;

    // Reset values, then an empty table.
    do_reset(1'b1);
    pulse_swap(0, s);
    expect_line("empty", s, 0, ng);

    // Single sprite fully on the line.
    do_reset(1'b0);
    ent_mem[0] = ent(1, 0, 100);
    pulse_swap(1, s);
    expect_line("single", s, 1, ng);
    check("single_count", ng, 48);

    // Right-edge clipping.
    do_reset(1'b0);
    ent_mem[0] = ent(1, 0, 620);
    pulse_swap(1, s);
    expect_line("clip", s, 1, ng);
    check("clip_count", ng, 20);

    // Colour-key transparency at k=5..9.
    do_reset(1'b0);
    ent_mem[0] = ent(2, 0, 200);
    pulse_swap(1, s);
    expect_line("transp", s, 1, ng);
    check("transp_count", ng, 43);

    // Painter's order: index 1 overwrites index 0.
    do_reset(1'b0);
    ent_mem[0] = ent(3, 0, 50);
    ent_mem[1] = ent(4, 0, 50);
    pulse_swap(2, s);
    expect_line("overlap", s, 2, ng);
    check("overlap_count", ng, 96);
    check("overlap_px50", lb_got[50], BLUE);
    check("overlap_px97", lb_got[97], BLUE);

    // Swap mid-DRAW aborts and restarts on the next row.
    do_reset(1'b0);
    ent_mem[0] = ent(1, 0, 100);
    pulse_swap(1, s);
    repeat (10) @(negedge clk);
    check("pre_abort_wren", wren, 1);
    pulse_swap(1, s2);
    check("abort_overrun", overrun, 1);
    check("abort_wren", wren, 0);
    expect_line("restart", s2, 1, ng);

    // Reset in the middle of a line stops all writes.
    ent_mem[0] = ent(1, 0, 100);
    pulse_swap(1, s);
    repeat (20) @(negedge clk);
    do_reset(1'b1);
    nw = writes.size();
    repeat (100) @(negedge clk);
    check("post_reset_writes", writes.size(), nw);

    // Randomized entity tables.
    for (int line = 0; line < 12; line++) begin
      n = $urandom_range(0, 6);
      nxt = (model_row == FRAME_H - 1) ? 0 : model_row + 1;
      for (int i = 0; i < n; i++) begin
        d = $urandom_range(0, 60);
        sr = (nxt >= d) ? nxt - d : $urandom_range(0, 1023);
        ent_mem[i] = ent($urandom_range(0, 7), sr, $urandom_range(0, 1023));
      end
      pulse_swap(n, s);
      expect_line("random", s, n, ng);
    end

    // Walk the row counter to the bottom of the frame and across the wrap.
    while (model_row != FRAME_H - 2) begin
      pulse_swap(0, s);
      expect_line("walk", s, 0, ng);
    end
    ent_mem[0] = ent(5, 460, 10);
    ent_mem[1] = ent(6, 0, 300);
    pulse_swap(2, s);
    expect_line("last_row", s, 2, ng);
    check("last_row_count", ng, 48);
    pulse_swap(2, s);
    expect_line("wrap_row0", s, 2, ng);
    check("wrap_row0_count", ng, 48);

    check("overrun_pulses", ovr_cnt, 1);
    check("idle_write_port", idle_bad, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
